floo_credit_wormhole_arbiter: RTL and testbench

Output-port arbiter for the FlooNoC router: shares one output link among `NumInputs` input ports using round-robin arbitration with wormhole packet locking, and enforces credit-based flow control toward the downstream router or network interface. One instance sits in front of each router output and each physical channel (req, rsp, wide). It replaces ready/valid backpressure on the link with a local credit counter.

---
 rtl/floo_pkg.sv | 14 +
 rtl/floo_credit_counter.sv | 57 +++++
 rtl/floo_credit_wormhole_arbiter.sv | 144 ++++++++++++++
 tb/tb_floo_credit_wormhole_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/floo_pkg.sv
// rtl/floo_pkg.sv - shared FlooNoC router types
//
// Purpose: types shared by the router arbiters.
// Ports:   none (package).

package floo_pkg;

   // Output arbiter state: free to pick a new winner, or held by a packet in flight.
   typedef enum logic [0:0] {
      ArbIdle   = 1'b0,
      ArbLocked = 1'b1
   } arb_state_e;

endpackage

// File: rtl/floo_credit_counter.sv
// rtl/floo_credit_counter.sv - downstream credit counter with saturation
//
// Purpose: tracks free downstream buffer slots for one output link.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   consume       a flit left on the link this cycle (takes one credit)
//   credit_i      downstream freed one slot this cycle
//   credits       current credit count (NumCredits after reset)
//   credit_err    sticky: a credit arrived while the counter was already full

module floo_credit_counter #(
   parameter int unsigned NumCredits = 4,
   parameter int unsigned CntWidth   = $clog2(NumCredits + 1)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                consume,
   input  logic                credit_i,
   output logic [CntWidth-1:0] credits,
   output logic                credit_err
);

   localparam logic [CntWidth-1:0] MaxCredits = CntWidth'(NumCredits);
   localparam logic [CntWidth-1:0] OneCredit  = CntWidth'(1);

   logic [CntWidth-1:0] credits_d;
   logic                credit_err_d;

   // Consume and return in the same cycle cancel out. A return at full is an
   // accounting error downstream; the count saturates instead of wrapping.
   always_comb begin
      credits_d    = credits;
      credit_err_d = credit_err;
      case ({consume, credit_i})
         2'b10: credits_d = credits - OneCredit;
         2'b01: begin
            if (credits == MaxCredits) begin
               credit_err_d = 1'b1;
            end else begin
               credits_d = credits + OneCredit;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         credits    <= MaxCredits;
         credit_err <= 1'b0;
      end else begin
         credits    <= credits_d;
         credit_err <= credit_err_d;
      end
   end

endmodule

// File: rtl/floo_credit_wormhole_arbiter.sv
// rtl/floo_credit_wormhole_arbiter.sv - round-robin wormhole output arbiter with credit flow control
//
// Purpose: shares one router output link among NumInputs inputs. Round-robin
// between packets, a packet holds the link until its tail (wormhole), and a
// flit only leaves when a downstream credit is available.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   valid_i        per-input flit valid
//   ready_o        per-input accept (one-hot or zero)
//   data_i         per-input flit payload
//   last_i         per-input tail marker
//   valid_o        flit sent on the link this cycle
//   data_o/last_o  flit and tail marker of the selected input
//   credit_i       one-cycle pulse, downstream freed one slot
//   locked_o       a packet currently owns the link
//   grant_idx_o    currently selected input
//   credit_cnt_o   current credit count
//   credit_err_o   sticky credit overflow flag

module floo_credit_wormhole_arbiter
   import floo_pkg::*;
#(
   parameter int unsigned NumInputs  = 5,
   parameter int unsigned NumCredits = 4,
   parameter type         flit_t     = logic,
   parameter int unsigned IdxWidth   = $clog2(NumInputs),
   parameter int unsigned CntWidth   = $clog2(NumCredits + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NumInputs-1:0] valid_i,
   output logic [NumInputs-1:0] ready_o,
   input  flit_t                data_i [NumInputs],
   input  logic [NumInputs-1:0] last_i,
   output logic                 valid_o,
   output flit_t                data_o,
   output logic                 last_o,
   input  logic                 credit_i,
   output logic                 locked_o,
   output logic [IdxWidth-1:0]  grant_idx_o,
   output logic [CntWidth-1:0]  credit_cnt_o,
   output logic                 credit_err_o
);

   arb_state_e          state_q, state_d;
   logic [IdxWidth-1:0] rr_ptr_q, rr_ptr_d;
   logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;
   logic [CntWidth-1:0] credits;
   logic [IdxWidth-1:0] winner;
   logic                win_last;
   logic                transfer;

   // Index after idx, wrapping at NumInputs (which need not be a power of two).
   function automatic logic [IdxWidth-1:0] wrap_inc(input logic [IdxWidth-1:0] idx);
      int unsigned nxt;
      nxt = (32'(idx) + 1) % NumInputs;
      return IdxWidth'(nxt);
   endfunction

   // Rotate requests so rr_ptr sits at bit 0, take the lowest set bit, then
   // rotate the position back. With no request this yields ptr itself.
   function automatic logic [IdxWidth-1:0] rr_select(input logic [NumInputs-1:0] req,
                                                     input logic [IdxWidth-1:0]  ptr);
      logic [2*NumInputs-1:0] dbl;
      logic [NumInputs-1:0]   rot;
      int unsigned            sel;
      dbl = {req, req} >> ptr;
      rot = dbl[NumInputs-1:0];
      sel = 0;
      for (int i = NumInputs - 1; i >= 0; i--) begin
         if (rot[i]) sel = i;
      end
      sel = (sel + 32'(ptr)) % NumInputs;
      return IdxWidth'(sel);
   endfunction

   always_comb begin
      winner   = (state_q == ArbLocked) ? lock_idx_q : rr_select(valid_i, rr_ptr_q);
      win_last = last_i[winner];
      // credit_i is deliberately absent here: a returned credit only counts
      // once it has been registered into the counter.
      transfer = !rst_i && valid_i[winner] && (credits != '0);

      valid_o = transfer;
      data_o  = data_i[winner];
      last_o  = win_last;
      ready_o = '0;
      if (transfer) ready_o[winner] = 1'b1;

      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      lock_idx_d = lock_idx_q;
      if (transfer) begin
         case (state_q)
            ArbIdle: begin
               if (win_last) begin
                  rr_ptr_d = wrap_inc(winner);
               end else begin
                  state_d    = ArbLocked;
                  lock_idx_d = winner;
               end
            end
            ArbLocked: begin
               // A stalled head input (valid low) simply waits here; the lock
               // is only released by the tail flit.
               if (win_last) begin
                  state_d  = ArbIdle;
                  rr_ptr_d = wrap_inc(lock_idx_q);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ArbIdle;
         rr_ptr_q   <= '0;
         lock_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         lock_idx_q <= lock_idx_d;
      end
   end

   floo_credit_counter #(
      .NumCredits (NumCredits),
      .CntWidth   (CntWidth)
   ) u_credit_counter (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .consume    (transfer),
      .credit_i   (credit_i),
      .credits    (credits),
      .credit_err (credit_err_o)
   );

   assign locked_o     = (state_q == ArbLocked) && !rst_i;
   assign grant_idx_o  = winner;
   assign credit_cnt_o = credits;

endmodule

// File: tb/tb_floo_credit_wormhole_arbiter.sv
// tb/tb_floo_credit_wormhole_arbiter.sv - scoreboard bench for the credit wormhole arbiter

module tb_floo_credit_wormhole_arbiter;

   typedef struct {
      logic [2:0] idx;
      logic [7:0] data;
      logic       last;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_i;
   logic [4:0] valid_i;
   logic [4:0] ready_o;
   logic [7:0] data_i [5];
   logic [4:0] last_i;
   logic       valid_o;
   logic [7:0] data_o;
   logic       last_o;
   logic       credit_i;
   logic       locked_o;
   logic [2:0] grant_idx_o;
   logic [2:0] credit_cnt_o;
   logic       credit_err_o;

   exp_t sb_q [$];
   int   errors = 0;
   int   checks = 0;
   logic vs;

   floo_credit_wormhole_arbiter #(
      .NumInputs  (5),
      .NumCredits (4),
      .flit_t     (logic [7:0])
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .valid_i      (valid_i),
      .ready_o      (ready_o),
      .data_i       (data_i),
      .last_i       (last_i),
      .valid_o      (valid_o),
      .data_o       (data_o),
      .last_o       (last_o),
      .credit_i     (credit_i),
      .locked_o     (locked_o),
      .grant_idx_o  (grant_idx_o),
      .credit_cnt_o (credit_cnt_o),
      .credit_err_o (credit_err_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] mkflit(input int i, input int s);
      return {3'(i), 5'(s)};
   endfunction

   task automatic push(input int i, input logic [7:0] d, input logic l);
      exp_t e;
      e.idx  = 3'(i);
      e.data = d;
      e.last = l;
      sb_q.push_back(e);
   endtask

   // Sample point of a cycle: away from the rising edge.
   task automatic settle();
      @(negedge clk);
      vs = valid_o;
   endtask

   // Start of the next cycle: drive the credit line for it.
   task automatic advance(input logic c);
      @(posedge clk);
      #1;
      credit_i = c;
   endtask

   // Every flit leaving on the link must be the next one the stimulus expected.
   always @(negedge clk) begin
      if (valid_o) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_flit", {29'd0, grant_idx_o}, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_grant_idx", 32'(grant_idx_o), 32'(e.idx));
            check("sb_data", 32'(data_o), 32'(e.data));
            check("sb_last", 32'(last_o), 32'(e.last));
            check("sb_ready_onehot", 32'(ready_o), 32'(5'(1) << e.idx));
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i    = 1'b1;
      valid_i  = '1;
      last_i   = '1;
      credit_i = 1'b0;
      vs       = 1'b0;
      for (int i = 0; i < 5; i++) data_i[i] = mkflit(i, 0);

      // Reset held with every input requesting.
      for (int k = 0; k < 3; k++) begin
         settle();
         check("rst_valid_o", 32'(valid_o), 0);
         check("rst_ready_o", 32'(ready_o), 0);
         check("rst_credit_cnt", 32'(credit_cnt_o), 4);
         check("rst_locked", 32'(locked_o), 0);
         advance(1'b0);
      end

      // Single-flit fairness, downstream returning each credit a cycle later.
      for (int i = 0; i < 5; i++) push(i, mkflit(i, 0), 1'b1);
      push(0, mkflit(0, 0), 1'b1);
      rst_i = 1'b0;
      for (int k = 0; k < 6; k++) begin
         settle();
         if (k > 0) check("fair_credit_cnt", 32'(credit_cnt_o), 3);
         advance(vs);
      end
      valid_i = '0;
      settle();
      check("fair_valid_off", 32'(valid_o), 0);
      advance(1'b0);
      settle();
      check("fair_credit_full", 32'(credit_cnt_o), 4);
      check("fair_sb_drained", sb_q.size(), 0);
      advance(1'b0);

      // Wormhole: input 2 sends 4 flits with a 2-cycle gap, input 3 waits.
      last_i     = '0;
      last_i[3]  = 1'b1;
      valid_i[3] = 1'b1;
      data_i[3]  = mkflit(3, 1);
      valid_i[2] = 1'b1;
      data_i[2]  = mkflit(2, 0);
      push(2, mkflit(2, 0), 1'b0);
      settle();
      check("wh_unlocked_head", 32'(locked_o), 0);
      advance(vs);
      data_i[2] = mkflit(2, 1);
      push(2, mkflit(2, 1), 1'b0);
      settle();
      check("wh_locked", 32'(locked_o), 1);
      advance(vs);
      valid_i[2] = 1'b0;
      for (int k = 0; k < 2; k++) begin
         settle();
         check("wh_stall_valid_o", 32'(valid_o), 0);
         check("wh_stall_ready3", 32'(ready_o[3]), 0);
         check("wh_stall_locked", 32'(locked_o), 1);
         check("wh_stall_grant", 32'(grant_idx_o), 2);
         advance(vs);
      end
      valid_i[2] = 1'b1;
      data_i[2]  = mkflit(2, 2);
      push(2, mkflit(2, 2), 1'b0);
      settle();
      advance(vs);
      data_i[2] = mkflit(2, 3);
      last_i[2] = 1'b1;
      push(2, mkflit(2, 3), 1'b1);
      push(3, mkflit(3, 1), 1'b1);
      settle();
      advance(vs);
      valid_i[2] = 1'b0;
      last_i[2]  = 1'b0;
      settle();
      check("wh_input3_after_tail", 32'(grant_idx_o), 3);
      check("wh_input3_valid", 32'(valid_o), 1);
      advance(vs);
      valid_i = '0;
      settle();
      advance(1'b0);
      settle();
      check("wh_credit_full", 32'(credit_cnt_o), 4);
      advance(1'b0);

      // Credit exhaustion: input 1 streams with no credits coming back.
      valid_i[1] = 1'b1;
      last_i[1]  = 1'b0;
      for (int s = 0; s < 4; s++) begin
         data_i[1] = mkflit(1, s);
         push(1, mkflit(1, s), 1'b0);
         settle();
         advance(1'b0);
      end
      data_i[1] = mkflit(1, 4);
      for (int k = 0; k < 2; k++) begin
         settle();
         check("ex_valid_off", 32'(valid_o), 0);
         check("ex_ready_off", 32'(ready_o), 0);
         check("ex_credit_zero", 32'(credit_cnt_o), 0);
         advance(k == 1);
      end
      settle();
      check("ex_credit_not_same_cycle", 32'(valid_o), 0);
      advance(1'b0);
      push(1, mkflit(1, 4), 1'b0);
      settle();
      check("ex_one_more_transfer", 32'(valid_o), 1);
      advance(1'b0);
      settle();
      check("ex_only_one", 32'(valid_o), 0);
      check("ex_credit_zero_again", 32'(credit_cnt_o), 0);

      // Return two credits while the locked input idles, then transfer and
      // credit together.
      advance(1'b1);
      valid_i[1] = 1'b0;
      settle();
      advance(1'b1);
      settle();
      advance(1'b0);
      settle();
      check("sim_credit_pre", 32'(credit_cnt_o), 2);
      advance(1'b1);
      valid_i[1] = 1'b1;
      last_i[1]  = 1'b1;
      data_i[1]  = mkflit(1, 5);
      push(1, mkflit(1, 5), 1'b1);
      settle();
      advance(1'b0);
      valid_i = '0;
      last_i  = '0;
      settle();
      check("sim_credit_hold", 32'(credit_cnt_o), 2);
      check("sim_unlocked_after_tail", 32'(locked_o), 0);
      check("sim_err_clear", 32'(credit_err_o), 0);

      // Refill to full, then one credit too many.
      advance(1'b1);
      settle();
      advance(1'b1);
      settle();
      advance(1'b1);
      settle();
      check("sat_credit_full", 32'(credit_cnt_o), 4);
      check("sat_err_before", 32'(credit_err_o), 0);
      advance(1'b0);
      settle();
      check("sat_credit_cnt", 32'(credit_cnt_o), 4);
      check("sat_err_set", 32'(credit_err_o), 1);
      advance(1'b0);
      settle();
      advance(1'b0);
      settle();
      check("sat_err_sticky", 32'(credit_err_o), 1);
      advance(1'b0);

      // Reset in the middle of a 5-flit packet from input 4.
      valid_i[4] = 1'b1;
      last_i[4]  = 1'b0;
      data_i[4]  = mkflit(4, 0);
      push(4, mkflit(4, 0), 1'b0);
      settle();
      advance(1'b0);
      data_i[4] = mkflit(4, 1);
      push(4, mkflit(4, 1), 1'b0);
      settle();
      check("mid_locked_before", 32'(locked_o), 1);
      advance(1'b0);
      data_i[4]  = mkflit(4, 2);
      rst_i      = 1'b1;
      valid_i[0] = 1'b1;
      last_i[0]  = 1'b1;
      data_i[0]  = mkflit(0, 7);
      settle();
      check("mid_rst_valid_o", 32'(valid_o), 0);
      check("mid_rst_ready_o", 32'(ready_o), 0);
      check("mid_rst_locked", 32'(locked_o), 0);
      advance(1'b0);
      rst_i = 1'b0;
      push(0, mkflit(0, 7), 1'b1);
      settle();
      check("mid_locked_after", 32'(locked_o), 0);
      check("mid_credit_restored", 32'(credit_cnt_o), 4);
      check("mid_err_cleared", 32'(credit_err_o), 0);
      check("mid_input0_first", 32'(grant_idx_o), 0);
      advance(1'b0);
      valid_i = '0;
      settle();
      check("mid_credit_after", 32'(credit_cnt_o), 3);
      check("final_sb_drained", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
